// File: rtl/md_hilo_if.sv
// md_hilo_if
//  Bundles the E/D-stage request side and the HI/LO result/stall side of the
//  mult/div sequencer.
//  master : pipeline side; drives e_start/e_op/e_rs/e_rt/d_uses_md and
//           receives busy/stall/fd_we/e_flush/hi/lo/proto_err.
//  slave  : md_hilo_ctrl side, with the opposite directions.
interface md_hilo_if;
    logic        e_start;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_uses_md;
    logic        busy;
    logic        stall;
    logic        fd_we;
    logic        e_flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        proto_err;

    modport master (
        output e_start, e_op, e_rs, e_rt, d_uses_md,
        input  busy, stall, fd_we, e_flush, hi, lo, proto_err
    );

    modport slave (
        input  e_start, e_op, e_rs, e_rt, d_uses_md,
        output busy, stall, fd_we, e_flush, hi, lo, proto_err
    );
endinterface

// File: rtl/md_hilo_ctrl.sv
// md_hilo_ctrl
//  E-stage sequencer for the multi-cycle mult/div unit and the HI/LO registers.
//  A mult/div is evaluated in full when it is accepted, held, and committed to
//  HI/LO once a busy counter modelling the unit latency expires. mthi/mtlo
//  write directly when the unit is idle. A combinational stall freezes PC and
//  F/D and bubbles E while a D-stage HI/LO instruction would hit a busy unit.
// Ports
//  clk, reset        : clock; synchronous active-high reset
//  bus (slave)       : e_start/e_op/e_rs/e_rt/d_uses_md in;
//                      busy/stall/fd_we/e_flush/hi/lo/proto_err out
module md_hilo_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_hilo_if.slave   bus
);
    // Sized for the longer latency; equals $clog2(DIV_CYCLES+1) whenever
    // division is the slower operation.
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic        res_we_q, res_we_d;   // 0 for a divide by zero: no writeback
    logic        perr_q, perr_d;

    // ---------------- arithmetic on the E operands ----------------
    logic [31:0] rs, rt;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, sdiv_b, udiv_b;
    logic [31:0] squ, sru, sq, sr, uq, ur;

    assign rs = bus.e_rs;
    assign rt = bus.e_rt;

    // Low 64 bits of a product of sign-extended operands are the signed product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0
    // because the magnitude 0x80000000 is representable unsigned.
    // Zero divisors are swapped for 1 only to keep the divider defined; the
    // result is discarded in that case.
    assign a_mag  = rs[31] ? (~rs + 32'd1) : rs;
    assign b_mag  = rt[31] ? (~rt + 32'd1) : rt;
    assign sdiv_b = (rt == 32'd0) ? 32'd1 : b_mag;
    assign squ    = a_mag / sdiv_b;
    assign sru    = a_mag % sdiv_b;
    assign sq     = (rs[31] ^ rt[31]) ? (~squ + 32'd1) : squ;
    assign sr     = rs[31] ? (~sru + 32'd1) : sru;

    assign udiv_b = (rt == 32'd0) ? 32'd1 : rt;
    assign uq     = rs / udiv_b;
    assign ur     = rs % udiv_b;

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_we_d = res_we_q;
        perr_d   = perr_q;

        case (state_q)
            IDLE: begin
                if (bus.e_start) begin
                    case (bus.e_op)
                        3'd0, 3'd1: begin
                            {res_hi_d, res_lo_d} = (bus.e_op == 3'd0) ? prod_s : prod_u;
                            res_we_d = 1'b1;
                            count_d  = MULT_N;
                            state_d  = BUSY;
                        end
                        3'd2, 3'd3: begin
                            res_hi_d = (bus.e_op == 3'd2) ? sr : ur;
                            res_lo_d = (bus.e_op == 3'd2) ? sq : uq;
                            res_we_d = (rt != 32'd0);
                            count_d  = DIV_N;
                            state_d  = BUSY;
                        end
                        3'd4:    hi_d = rs;
                        3'd5:    lo_d = rs;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // A start here means the pipeline failed to stall; drop it.
                if (bus.e_start)
                    perr_d = 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    if (res_we_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_we_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_we_q <= res_we_d;
            perr_q   <= perr_d;
        end
    end

    // ---------------- outputs ----------------
    // The e_start term covers the cycle a mult/div sits in E before busy rises.
    assign bus.busy      = (state_q == BUSY);
    assign bus.stall     = bus.d_uses_md & (bus.busy | (bus.e_start & ~bus.e_op[2]));
    assign bus.fd_we     = ~bus.stall;
    assign bus.e_flush   = bus.stall;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_md_hilo_ctrl.sv
module tb_md_hilo_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    md_hilo_if bus();

    md_hilo_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy, stall, fd_we, e_flush, perr;
        logic [31:0] hi, lo;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
    int          m_left;   // busy cycles still to run
    bit          m_rv, m_err;

    function automatic void calc(input logic [2:0] op, input logic [31:0] a, b,
                                 output logic [31:0] rh, rl, output bit ok);
        longint x, y, p, qq, rr;
        ok = 1'b1; rh = '0; rl = '0;
        case (op)
            3'd0: begin x = longint'($signed(a)); y = longint'($signed(b)); p = x * y;
                        rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin x = longint'({32'd0, a}); y = longint'({32'd0, b}); p = x * y;
                        rh = p[63:32]; rl = p[31:0]; end
            3'd2: if (b == 0) ok = 1'b0;
                  else begin x = longint'($signed(a)); y = longint'($signed(b));
                        qq = x / y; rr = x % y; rl = qq[31:0]; rh = rr[31:0]; end
            default: if (b == 0) ok = 1'b0;
                  else begin x = longint'({32'd0, a}); y = longint'({32'd0, b});
                        qq = x / y; rr = x % y; rl = qq[31:0]; rh = rr[31:0]; end
        endcase
    endfunction

    function automatic void model_edge(input bit rst, st, input logic [2:0] op,
                                       input logic [31:0] a, b);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_rv = 0; m_err = 0;
        end else if (m_left > 0) begin
            if (st) m_err = 1;
            m_left--;
            if (m_left == 0 && m_rv) begin m_hi = m_rhi; m_lo = m_rlo; end
        end else if (st) begin
            if (op <= 3) begin
                calc(op, a, b, m_rhi, m_rlo, m_rv);
                m_left = (op <= 1) ? MULT_N : DIV_N;
            end else if (op == 4) m_hi = a;
            else if (op == 5) m_lo = a;
        end
    endfunction

    // One clock cycle: drive inputs, record the expected outputs of this cycle,
    // then advance the model across the edge.
    task automatic step(input bit rst, st, input logic [2:0] op,
                        input logic [31:0] a, b, input bit duse, input bit chk = 1'b1);
        exp_t e;
        reset = rst; bus.e_start = st; bus.e_op = op;
        bus.e_rs = a; bus.e_rt = b; bus.d_uses_md = duse;
        if (chk) begin
            e.busy    = (m_left > 0);
            e.stall   = duse & (e.busy | (st & (op <= 3)));
            e.fd_we   = ~e.stall;
            e.e_flush = e.stall;
            e.perr    = m_err;
            e.hi      = m_hi;
            e.lo      = m_lo;
            q.push_back(e);
        end
        @(posedge clk);
        model_edge(rst, st, op, a, b);
        #1;
    endtask

    task automatic idle(input int n, input bit duse = 1'b0);
        for (int i = 0; i < n; i++) step(0, 0, 3'd7, 32'h0, 32'h0, duse);
    endtask

    // Directed check against constants taken straight from the behaviour rules.
    task automatic expect_val(input string name, input logic [31:0] act, exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_chk++;
                if ({bus.busy, bus.stall, bus.fd_we, bus.e_flush, bus.proto_err} ===
                    {e.busy, e.stall, e.fd_we, e.e_flush, e.perr}) n_pass++;
                else $display("FAIL ctl(busy,stall,fd_we,e_flush,perr): got %b expected %b at %0t",
                              {bus.busy, bus.stall, bus.fd_we, bus.e_flush, bus.proto_err},
                              {e.busy, e.stall, e.fd_we, e.e_flush, e.perr}, $time);
                n_chk++;
                if (bus.hi === e.hi) n_pass++;
                else $display("FAIL hi: got %h expected %h at %0t", bus.hi, e.hi, $time);
                n_chk++;
                if (bus.lo === e.lo) n_pass++;
                else $display("FAIL lo: got %h expected %h at %0t", bus.lo, e.lo, $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'd7};

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        m_hi = 0; m_lo = 0; m_rhi = 0; m_rlo = 0; m_left = 0; m_rv = 0; m_err = 0;
        step(1, 0, 3'd7, 0, 0, 0, 0);   // state unknown before first reset
        step(1, 0, 3'd7, 0, 0, 0);

        // 1: idle after reset
        idle(2);
        expect_val("reset_hi", bus.hi, 32'h0);
        expect_val("reset_fd_we", {31'd0, bus.fd_we}, 32'd1);

        // 2: MULT -3 * 7
        step(0, 1, 3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        for (int i = 0; i < MULT_N - 1; i++) begin
            idle(1);
            expect_val("mult_busy", {31'd0, bus.busy}, 32'd1);
        end
        idle(1);
        expect_val("mult_hi", bus.hi, 32'hFFFF_FFFF);
        expect_val("mult_lo", bus.lo, 32'hFFFF_FFEB);
        expect_val("mult_done_busy", {31'd0, bus.busy}, 32'd0);

        // 3: DIV -7 / 2 with a D-stage HI/LO instruction waiting
        step(0, 1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1);
        idle(DIV_N, 1);
        expect_val("div_lo", bus.lo, 32'hFFFF_FFFD);
        expect_val("div_hi", bus.hi, 32'hFFFF_FFFF);
        expect_val("div_stall_after", {31'd0, bus.stall}, 32'd0);

        // 4: MTHI then MULTU 0xFFFFFFFF * 2, back to back
        step(0, 1, 3'd4, 32'h1234, 32'h0, 0);
        expect_val("mthi", bus.hi, 32'h1234);
        step(0, 1, 3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        idle(MULT_N);
        expect_val("multu_hi", bus.hi, 32'h1);
        expect_val("multu_lo", bus.lo, 32'hFFFF_FFFE);

        // 5: DIVU by zero leaves HI/LO; start while busy flags proto_err
        step(0, 1, 3'd4, 32'd5, 32'h0, 0);
        step(0, 1, 3'd5, 32'd5, 32'h0, 0);
        step(0, 1, 3'd3, 32'd99, 32'h0, 0);
        idle(3);
        step(0, 1, 3'd0, 32'd3, 32'd3, 0);
        idle(DIV_N - 4);
        expect_val("div0_hi", bus.hi, 32'd5);
        expect_val("div0_lo", bus.lo, 32'd5);
        expect_val("proto_err", {31'd0, bus.proto_err}, 32'd1);

        // 0x80000000 / -1
        step(1, 0, 3'd7, 0, 0, 0);
        step(0, 1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle(DIV_N);
        expect_val("ovf_lo", bus.lo, 32'h8000_0000);
        expect_val("ovf_hi", bus.hi, 32'h0);

        // 6: reset in the middle of a DIV
        step(0, 1, 3'd2, 32'd100, 32'd7, 0);
        idle(2);
        step(1, 0, 3'd7, 0, 0, 0);
        expect_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        expect_val("abort_hi", bus.hi, 32'h0);
        idle(DIV_N);
        expect_val("abort_lo", bus.lo, 32'h0);

        // Random traffic, mostly well-behaved, with occasional protocol violations
        for (int i = 0; i < 800; i++) begin
            bit st, rst;
            rst = ($urandom_range(0, 99) == 0);
            st  = (m_left > 0) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1);
            step(rst, st, 3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
        end
        idle(2);

        @(negedge clk); #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
